// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO writer driver and the drain checker.
// Holds the default data width and the run-state encoding.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FULL,
    DRAIN,
    FLUSH,
    DONE
  } fifo_state_t;

endpackage

// File: rtl/fifo_rd_latency_pipe.sv
// Valid-bit shift register that tracks accepted FIFO reads until their data
// appears on the FIFO output, LATENCY cycles after the accept edge.
module fifo_rd_latency_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic out_valid
);

  logic [LATENCY-1:0] shift;

  // Shift left; the casted concatenation drops the oldest bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift <= '0;
    end else begin
      shift <= LATENCY'({shift, in_valid});
    end
  end

  assign out_valid = shift[LATENCY-1];

endmodule

// File: rtl/fifo_drain_checker.sv
// Drains TOTAL words from a FIFO read port, stores them in a capture buffer and
// checks each word against the EXP_BASE + i*EXP_STEP pattern the writer pushes.
module fifo_drain_checker
  import fifo_pkg::*;
#(
  parameter int unsigned          DATA_W       = FIFO_DATA_W,
  parameter int unsigned          TOTAL        = 32,
  parameter int unsigned          READ_LATENCY = 1,
  parameter logic [DATA_W-1:0]    EXP_BASE     = '0,
  parameter logic [DATA_W-1:0]    EXP_STEP     = DATA_W'(2),
  localparam int unsigned         CNT_W        = $clog2(TOTAL + 1),
  localparam int unsigned         ADDR_W       = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              burst_mode,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_index,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  input  logic [ADDR_W-1:0] buf_rd_addr,
  output logic [DATA_W-1:0] buf_rd_data
);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

  fifo_state_t       state, state_next;
  logic [CNT_W-1:0]  issued, captured;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] mem [TOTAL];
  logic              start_run, pipe_valid, capture;

  assign start_run = start && (state == IDLE || state == DONE);
  assign fifo_read = (state == DRAIN) && !fifo_empty && (issued < TOTAL_C);
  assign capture   = pipe_valid && (state == DRAIN || state == FLUSH);

  fifo_rd_latency_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fifo_read),
    .out_valid (pipe_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start)                 state_next = burst_mode ? WAIT_FULL : DRAIN;
      WAIT_FULL:  if (fifo_full)             state_next = DRAIN;
      DRAIN:      if (issued == TOTAL_C)     state_next = FLUSH;
      FLUSH:      if (captured == TOTAL_C)   state_next = DONE;
      default:                               state_next = IDLE;
    endcase
  end

  // Issue/capture counters, running expected value and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued        <= '0;
      captured      <= '0;
      exp_word      <= EXP_BASE;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_index     <= '0;
      done          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= TOTAL_C;
    end else begin
      out_valid <= capture;
      done      <= (state_next == DONE);
      if (start_run) begin
        issued        <= '0;
        captured      <= '0;
        exp_word      <= EXP_BASE;
        err_count     <= '0;
        first_err_idx <= TOTAL_C;
      end else begin
        if (fifo_read) begin
          issued <= issued + CNT_W'(1);
        end
        if (capture) begin
          out_data  <= fifo_data;
          out_index <= captured;
          captured  <= captured + CNT_W'(1);
          exp_word  <= exp_word + EXP_STEP;
          if (fifo_data != exp_word) begin
            err_count <= err_count + CNT_W'(1);
            if (err_count == '0) begin
              first_err_idx <= captured;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[ADDR_W'(captured)] <= fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_rd_data <= '0;
    end else begin
      buf_rd_data <= mem[buf_rd_addr];
    end
  end

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Bench for fifo_drain_checker: queue-based FIFO with read latency, randomized
// writer, and a per-cycle comparison of the checker outputs against a pattern model.
module tb_fifo_drain_checker;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TOTAL  = 32;
  localparam int unsigned RL     = 2;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam int unsigned ADDR_W = $clog2(TOTAL);
  localparam logic [DATA_W-1:0] EXP_BASE = 32'd0;
  localparam logic [DATA_W-1:0] EXP_STEP = 32'd2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              burst_mode = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              fifo_full = 1'b0;
  logic [DATA_W-1:0] fifo_data = '0;
  logic [ADDR_W-1:0] buf_rd_addr = '0;
  logic              fifo_read, out_valid, done;
  logic [DATA_W-1:0] out_data, buf_rd_data;
  logic [CNT_W-1:0]  out_index, err_count, first_err_idx;

  fifo_drain_checker #(
    .DATA_W       (DATA_W),
    .TOTAL        (TOTAL),
    .READ_LATENCY (RL),
    .EXP_BASE     (EXP_BASE),
    .EXP_STEP     (EXP_STEP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .burst_mode    (burst_mode),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_data     (fifo_data),
    .fifo_read     (fifo_read),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_index     (out_index),
    .done          (done),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .buf_rd_addr   (buf_rd_addr),
    .buf_rd_data   (buf_rd_data)
  );

  always #5 clk = ~clk;

  // Model state for the current run.
  logic [DATA_W-1:0] written [TOTAL];
  logic [DATA_W-1:0] q [$];
  logic [DATA_W-1:0] dpipe [RL];
  int  wr_ptr = TOTAL;
  int  cap_cnt = 0;
  int  stall = 0;
  int  stall_after = -1;
  int  push_pct = 100;
  bit  chk_en = 0, done_exp = 0, done_pending = 0, burst_run = 0, full_seen = 0;
  logic rd_acc = 1'b0;
  int  tests = 0, fails = 0;

  function automatic logic [DATA_W-1:0] pattern(int i);
    return EXP_BASE + DATA_W'(i) * EXP_STEP;
  endfunction

  function automatic int mism(int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (written[i] != pattern(i)) c++;
    return c;
  endfunction

  function automatic int first_mism(int n);
    for (int i = 0; i < n; i++) if (written[i] != pattern(i)) return i;
    return TOTAL;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read accepted at this edge, sampled before the DUT state updates.
  always @(posedge clk) rd_acc <= fifo_read;

  always @(negedge clk) begin : fifo_model
    logic [DATA_W-1:0] d;
    bit popped;
    if (reset) begin
      q.delete();
      for (int i = 0; i < RL; i++) dpipe[i] = $urandom;
      stall = 0;
      fifo_empty = 1'b1;
      fifo_full  = 1'b0;
      fifo_data  = dpipe[RL-1];
    end else begin
      if (chk_en) begin
        if (done_pending) done_exp = 1;
        if (out_valid) begin
          chk("extra_capture", cap_cnt < TOTAL, 1);
          if (cap_cnt < TOTAL) begin
            chk("out_index", out_index, cap_cnt);
            chk("out_data", out_data, written[cap_cnt]);
            cap_cnt++;
            if (cap_cnt == TOTAL) done_pending = 1;
          end
        end
        chk("err_count", err_count, mism(cap_cnt));
        chk("first_err_idx", first_err_idx, first_mism(cap_cnt));
        chk("done", done, done_exp);
      end
      popped = 0;
      d = $urandom;
      if (rd_acc) begin
        chk("no_overread", q.size() != 0, 1);
        if (burst_run) chk("burst_wait_full", full_seen, 1);
        if (q.size() != 0) begin
          d = q.pop_front();
          popped = 1;
        end
      end
      for (int i = RL - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
      dpipe[0] = popped ? d : $urandom;
      if (stall > 0) begin
        stall--;
      end else if (wr_ptr < TOTAL && q.size() < DEPTH && int'($urandom_range(99)) < push_pct) begin
        q.push_back(written[wr_ptr]);
        if (wr_ptr == stall_after) stall = 10;
        wr_ptr++;
      end
      fifo_empty = (q.size() == 0);
      fifo_full  = (q.size() == DEPTH);
      if (fifo_full) full_seen = 1;
      fifo_data  = dpipe[RL-1];
    end
  end

  task automatic start_run(bit bm, int pct, int st_after, int c1, logic [DATA_W-1:0] v1,
                           int c2, logic [DATA_W-1:0] v2);
    @(posedge clk); #1;
    for (int i = 0; i < TOTAL; i++) written[i] = pattern(i);
    if (c1 >= 0) written[c1] = v1;
    if (c2 >= 0) written[c2] = v2;
    chk_en = 0; push_pct = pct; stall_after = st_after; stall = 0;
    burst_run = bm; full_seen = 0; wr_ptr = 0;
    start = 1'b1; burst_mode = bm;
    @(posedge clk); #1;
    start = 1'b0; burst_mode = 1'b0;
    cap_cnt = 0; done_exp = 0; done_pending = 0; chk_en = 1;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!done && n < 4000) begin @(posedge clk); #1; n++; end
    chk({name, "_done_reached"}, done, 1);
  endtask

  task automatic end_checks(string name, int exp_err, int exp_first);
    chk({name, "_captured"}, cap_cnt, TOTAL);
    chk({name, "_err_count"}, err_count, exp_err);
    chk({name, "_first_err"}, first_err_idx, exp_first);
  endtask

  task automatic buf_check(int addr, logic [DATA_W-1:0] exp);
    buf_rd_addr = ADDR_W'(addr);
    @(posedge clk); #1;
    chk("buf_rd_data", buf_rd_data, exp);
  endtask

  task automatic reset_checks(string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_err_count"}, err_count, 0);
    chk({name, "_first_err"}, first_err_idx, TOTAL);
    chk({name, "_out_index"}, out_index, 0);
    chk({name, "_out_data"}, out_data, 0);
    chk({name, "_buf_rd_data"}, buf_rd_data, 0);
    chk({name, "_fifo_read"}, fifo_read, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    reset = 1'b0;

    // Stream mode, clean pattern 0,2,..,62.
    start_run(0, 100, -1, -1, '0, -1, '0);
    wait_done("stream");
    end_checks("stream", 0, 32);
    buf_check(31, 32'd62);

    // Burst mode: no reads until the 16-deep FIFO reports full.
    start_run(1, 70, -1, -1, '0, -1, '0);
    wait_done("burst");
    end_checks("burst", 0, 32);

    // Corrupted words 5 and 9.
    start_run(0, 60, -1, 5, 32'd11, 9, 32'hDEAD);
    wait_done("corrupt");
    end_checks("corrupt", 2, 5);
    buf_check(5, 32'd11);
    buf_check(9, 32'hDEAD);
    buf_check(0, 32'd0);

    // Writer stall after word 7, plus a start pulse mid-run that must be ignored.
    start_run(0, 100, 7, -1, '0, -1, '0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; burst_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; burst_mode = 1'b0;
    wait_done("stall");
    end_checks("stall", 0, 32);

    // Reset mid-drain after 12 captures, then a fresh run from index 0.
    start_run(0, 100, -1, -1, '0, -1, '0);
    n = 0;
    while (cap_cnt < 12 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("midrun_reached_12", cap_cnt >= 12, 1);
    reset = 1'b1; chk_en = 0; wr_ptr = TOTAL;
    @(posedge clk); @(posedge clk); #1;
    reset_checks("midrun_reset");
    reset = 1'b0;
    start_run(0, 80, -1, -1, '0, -1, '0);
    wait_done("post_reset");
    end_checks("post_reset", 0, 32);

    // Randomized runs checked purely against the model.
    for (int r = 0; r < 4; r++) begin
      c = int'($urandom_range(TOTAL - 1));
      start_run(1'($urandom_range(1)), 30 + int'($urandom_range(70)), int'($urandom_range(TOTAL - 1)),
                c, pattern(c) ^ (32'd1 << $urandom_range(31)), -1, '0);
      wait_done("random");
      end_checks("random", mism(TOTAL), first_mism(TOTAL));
      buf_check(c, written[c]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
